// File: rtl/wave_display_reader_pkg.sv
// -----------------------------------------------------------------------------
// wave_display_reader_pkg
//
// Shared definitions for the waveform RAM and its display-side reader.
// The waveform RAM is 512 x 8, split into two 256-sample halves. The capture
// block writes one half while the display block scans the other. Bit 8 of
// the RAM address selects the half.
//
// Contents:
//   - RAM geometry: address width, samples per half, sample width.
//   - Display window geometry: a square window, 512 pixels on a side.
//   - stage1_t: the pipeline record that travels alongside the RAM read.
// -----------------------------------------------------------------------------
package wave_display_reader_pkg;

  // RAM geometry.
  localparam int WAVE_RAM_AW       = 9;
  localparam int WAVE_HALF_SAMPLES = 256;
  localparam int WAVE_SAMPLE_W     = 8;

  // Display window geometry. Each sample spans 2 columns, and each row code
  // spans 2 rows, so 256 samples x 256 levels fill a 512 x 512 window.
  localparam int WAVE_WIN_SIZE = 512;
  localparam int WAVE_COORD_W  = 11;

  // Width of the per-half sample index.
  localparam int WAVE_SI_W = WAVE_RAM_AW - 1;

  typedef logic [WAVE_SAMPLE_W-1:0] sample_t;
  typedef logic [WAVE_SI_W-1:0]     sample_idx_t;
  typedef logic [WAVE_COORD_W-1:0]  coord_t;

  // Pixel context captured in the cycle that the RAM address is issued. It is
  // consumed one cycle later, when read_value is valid for that address.
  typedef struct packed {
    logic        in_win;  // pixel lies inside the display window
    logic        first;   // leftmost window column (ox == 0)
    sample_idx_t si;      // sample index addressed for this pixel
    sample_t     yc;      // row code within the window, top = 0
  } stage1_t;

endpackage : wave_display_reader_pkg

// File: rtl/wave_segment_hit.sv
// -----------------------------------------------------------------------------
// wave_segment_hit
//
// Purely combinational test of whether one display row falls on the vertical
// segment that joins two adjacent samples. The segment covers every level
// from min(prev, cur) to max(prev, cur), and both ends are included. A flat
// segment (prev == cur) therefore hits exactly one level.
//
// The row code counts down the screen, but sample values count up. The code
// is therefore inverted before the compare. Sample 255 then lands on the top
// row code, and sample 0 lands on the bottom row code.
//
// Ports:
//   prev  in  8  sample value at the left end of the segment
//   cur   in  8  sample value at the right end of the segment
//   yc    in  8  row code within the window (0 = top)
//   hit   out 1  row yc lies on the segment
// -----------------------------------------------------------------------------
module wave_segment_hit
  import wave_display_reader_pkg::*;
(
  input  sample_t prev,
  input  sample_t cur,
  input  sample_t yc,
  output logic    hit
);

  sample_t lo;
  sample_t hi;
  sample_t level;

  // NOTE: every signal assigned in always_comb receives a value on every path.
  // This block has no default-free branch, so no latch can be inferred.
  always_comb begin
    level = ~yc;
    if (prev <= cur) begin
      lo = prev;
      hi = cur;
    end else begin
      lo = cur;
      hi = prev;
    end
    hit = (lo <= level) && (level <= hi);
  end

endmodule : wave_segment_hit

// File: rtl/wave_display_reader.sv
// -----------------------------------------------------------------------------
// wave_display_reader
//
// Read side of the double-buffered 512x8 waveform RAM. The block scans the
// half that the capture block has released. The VGA x coordinate selects the
// sample, and the block draws a connected waveform two pixels wide inside a
// 512x512 window.
//
// Pipeline (2-cycle latency from x/y to pixel outputs):
//   C0  read_address = {rd_idx_q, si} is issued combinationally, and the
//       pixel context is captured into stage1.
//   C1  read_value is valid for the stage1 sample. The held prev/cur pair is
//       advanced when a new sample begins, and the lit decision uses the
//       advanced values directly.
//   C2  valid_pixel and r/g/b are registered.
//
// The buffer half (rd_idx_q) only follows read_index while
// wave_display_idle is high. The half can therefore never change while window
// pixels are being scanned.
//
// Ports:
//   clk                in   1   system clock
//   reset              in   1   asynchronous reset, active low
//   x                  in  11   current VGA column
//   y                  in  10   current VGA row
//   valid              in   1   x/y inside the visible area
//   read_index         in   1   half released by the writer for display
//   read_value         in   8   RAM data, valid 1 cycle after read_address
//   read_address       out  9   {rd_idx_q, sample index}
//   valid_pixel        out  1   pixel lies on the waveform
//   r, g, b            out  8   pixel colour (WAVE_COLOR when lit, else 0)
//   wave_display_idle  out  1   scan is outside the window rows; swap allowed
// -----------------------------------------------------------------------------
module wave_display_reader
  import wave_display_reader_pkg::*;
#(
  parameter int          X_START    = 256,
  parameter int          Y_START    = 0,
  parameter logic [23:0] WAVE_COLOR = 24'hFFFFFF
)(
  input  logic        clk,
  input  logic        reset,
  input  logic [10:0] x,
  input  logic [9:0]  y,
  input  logic        valid,
  input  logic        read_index,
  input  logic [7:0]  read_value,
  output logic [8:0]  read_address,
  output logic        valid_pixel,
  output logic [7:0]  r,
  output logic [7:0]  g,
  output logic [7:0]  b,
  output logic        wave_display_idle
);

  localparam coord_t WIN_SIZE = coord_t'(WAVE_WIN_SIZE);
  localparam coord_t X_OFS    = coord_t'(X_START);
  localparam coord_t Y_OFS    = coord_t'(Y_START);

  // ---------------------------------------------------------------------------
  // C0: window membership and address generation
  // ---------------------------------------------------------------------------
  coord_t  ox;
  coord_t  oy;
  logic    in_win;
  logic    rd_idx_q;
  stage1_t s1_d;
  stage1_t s1_q;

  // Unsigned 11-bit offsets. Coordinates left of or above the window wrap to
  // large values, so a single "< WIN_SIZE" test covers both edges.
  always_comb begin
    ox        = x - X_OFS;
    oy        = {1'b0, y} - Y_OFS;
    in_win    = valid && (ox < WIN_SIZE) && (oy < WIN_SIZE);
    s1_d.in_win = in_win;
    s1_d.first  = (ox == '0);
    s1_d.si     = ox[WAVE_SI_W:1];
    s1_d.yc     = oy[WAVE_SI_W:1];
  end

  // The address keeps tracking x outside the window. Those reads are
  // harmless, because nothing outside the window is lit.
  assign read_address = {rd_idx_q, s1_d.si};

  // NOTE: the reset here is asynchronous and active low. Every register in
  // this block is cleared on reset, because the design holds only a few
  // pipeline flops and no memory array.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only. All
      // flops then sample their pre-edge values, whatever the block order.
      s1_q <= s1_d;
    end
  end

  // ---------------------------------------------------------------------------
  // C1: sample pair tracking and segment hit test
  // ---------------------------------------------------------------------------
  sample_t     held_prev_q;
  sample_t     held_cur_q;
  sample_idx_t last_si_q;
  logic        new_si;
  sample_t     prev_eff;
  sample_t     cur_eff;
  logic        seg_hit;
  logic        lit;

  // A new sample begins when the index changes, or at the start of a row.
  // At a row start, prev is forced equal to cur. This stops a line being drawn
  // from the last sample of the previous row.
  always_comb begin
    new_si   = s1_q.first || (s1_q.si != last_si_q);
    prev_eff = held_prev_q;
    cur_eff  = held_cur_q;
    if (new_si) begin
      prev_eff = s1_q.first ? read_value : held_cur_q;
      cur_eff  = read_value;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      held_prev_q <= '0;
      held_cur_q  <= '0;
      last_si_q   <= '0;
    end else if (new_si) begin
      held_prev_q <= prev_eff;
      held_cur_q  <= cur_eff;
      last_si_q   <= s1_q.si;
    end
  end

  wave_segment_hit u_segment_hit (
    .prev (prev_eff),
    .cur  (cur_eff),
    .yc   (s1_q.yc),
    .hit  (seg_hit)
  );

  assign lit = s1_q.in_win && seg_hit;

  // ---------------------------------------------------------------------------
  // C2: registered pixel outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_pixel <= 1'b0;
      r           <= '0;
      g           <= '0;
      b           <= '0;
    end else begin
      valid_pixel <= lit;
      {r, g, b}   <= lit ? WAVE_COLOR : 24'h0;
    end
  end

  // ---------------------------------------------------------------------------
  // Idle flag and buffer-half select
  // ---------------------------------------------------------------------------
  // Idle is high whenever no visible window row is being scanned. The half is
  // sampled only while idle is high, which freezes it for the whole window
  // frame. A read_index change in the same cycle that idle drops is therefore
  // not captured until the next idle period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wave_display_idle <= 1'b0;
      rd_idx_q          <= 1'b0;
    end else begin
      wave_display_idle <= !valid || (oy >= WIN_SIZE);
      if (wave_display_idle) begin
        rd_idx_q <= read_index;
      end
    end
  end

endmodule : wave_display_reader

// File: tb/tb_wave_display_reader.sv
// -----------------------------------------------------------------------------
// tb_wave_display_reader
//
// Directed testbench for wave_display_reader. A behavioural registered RAM
// returns ram[read_address] one clock after the address is presented. Inputs
// are driven on the falling edge, and outputs are sampled on the falling
// edge just before the next drive.
//
// Expected row images come from a closed-form model. At column ox the segment
// joins sample si-1 and sample si, where si = ox/2. Column 0 and column 1
// (si == 0) form a single point. Row code yc is lit when 255 - yc lies
// between the two samples.
// -----------------------------------------------------------------------------
module tb_wave_display_reader;

  localparam int          X_START    = 256;
  localparam int          Y_START    = 0;
  localparam logic [23:0] WAVE_COLOR = 24'hFFFFFF;

  logic        clk;
  logic        reset;
  logic [10:0] x;
  logic [9:0]  y;
  logic        valid;
  logic        read_index;
  logic [7:0]  read_value;
  logic [8:0]  read_address;
  logic        valid_pixel;
  logic [7:0]  r, g, b;
  logic        wave_display_idle;

  logic [7:0]  ram [512];
  logic        obs_vp  [512];
  logic [23:0] obs_rgb [512];

  int pass_cnt  = 0;
  int total_cnt = 0;

  wave_display_reader #(
    .X_START    (X_START),
    .Y_START    (Y_START),
    .WAVE_COLOR (WAVE_COLOR)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .x                 (x),
    .y                 (y),
    .valid             (valid),
    .read_index        (read_index),
    .read_value        (read_value),
    .read_address      (read_address),
    .valid_pixel       (valid_pixel),
    .r                 (r),
    .g                 (g),
    .b                 (b),
    .wave_display_idle (wave_display_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered RAM model: data is valid one cycle after the address.
  initial read_value = 8'h00;
  always @(posedge clk) read_value <= ram[read_address];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  function automatic bit model_lit(input int ox, input int oy, input int half);
    int si, yv, cur, prev, lo, hi;
    si   = ox / 2;
    yv   = 255 - (oy / 2);
    cur  = int'(ram[half * 256 + si]);
    prev = (si == 0) ? cur : int'(ram[half * 256 + si - 1]);
    lo   = (prev < cur) ? prev : cur;
    hi   = (prev < cur) ? cur : prev;
    return (yv >= lo) && (yv <= hi);
  endfunction

  // Scans one full window row from ox = 0 and captures the output for each
  // column. The row then continues with out-of-window columns on the same
  // line, so valid stays high and the idle flag stays low.
  task automatic scan_row(input int oy);
    for (int i = 0; i < 514; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        obs_vp[i-2]  = valid_pixel;
        obs_rgb[i-2] = {r, g, b};
      end
      valid = 1'b1;
      y     = 10'(Y_START + oy);
      x     = (i < 512) ? 11'(X_START + i) : 11'(X_START + 512);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0; x = '0; y = '0; valid = 1'b1; read_index = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++; if (valid_pixel !== 1'b0) $display("FAIL reset_vp: got %b want 0", valid_pixel); else pass_cnt++;
    total_cnt++; if ({r, g, b} !== 24'h0) $display("FAIL reset_rgb: got %h want 0", {r, g, b}); else pass_cnt++;
    total_cnt++; if (wave_display_idle !== 1'b0) $display("FAIL reset_idle: got %b want 0", wave_display_idle); else pass_cnt++;
    total_cnt++; if (read_address[8] !== 1'b0) $display("FAIL reset_half: got %b want 0", read_address[8]); else pass_cnt++;
    reset = 1'b1;
    @(negedge clk);
    total_cnt++; if (valid_pixel !== 1'b0) $display("FAIL post_reset_vp: got %b want 0", valid_pixel); else pass_cnt++;
    total_cnt++; if (read_address[8] !== 1'b0) $display("FAIL post_reset_half: got %b want 0", read_address[8]); else pass_cnt++;
  endtask

  task automatic test_flat;
    int rows [5] = '{253, 254, 255, 256, 0};
    for (int i = 0; i < 256; i++) ram[i] = 8'd128;
    // Quiet the pipeline, then measure the latency of a single lit pixel.
    valid = 1'b0;
    repeat (2) @(negedge clk);
    valid = 1'b1; x = 11'(X_START); y = 10'(Y_START + 254);
    @(negedge clk);
    valid = 1'b0;
    total_cnt++; if (valid_pixel !== 1'b0) $display("FAIL latency_1cyc: got %b want 0", valid_pixel); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (valid_pixel !== 1'b1) $display("FAIL latency_2cyc: got %b want 1", valid_pixel); else pass_cnt++;
    total_cnt++; if ({r, g, b} !== WAVE_COLOR) $display("FAIL latency_rgb: got %h want %h", {r, g, b}, WAVE_COLOR); else pass_cnt++;
    for (int k = 0; k < 5; k++) begin
      scan_row(rows[k]);
      for (int c = 0; c < 512; c++) begin
        logic e;
        e = model_lit(c, rows[k], 0);
        total_cnt++;
        if (obs_vp[c] !== e || obs_rgb[c] !== (e ? WAVE_COLOR : 24'h0))
          $display("FAIL flat_row%0d_col%0d: got vp=%b rgb=%h want vp=%b", rows[k], c, obs_vp[c], obs_rgb[c], e);
        else pass_cnt++;
      end
      if (rows[k] == 254) begin
        total_cnt++; if (obs_vp[0] !== 1'b1 || obs_vp[511] !== 1'b1) $display("FAIL flat_254_edges: got %b%b want 11", obs_vp[0], obs_vp[511]); else pass_cnt++;
      end
      if (rows[k] == 256) begin
        total_cnt++; if (obs_vp[300] !== 1'b0) $display("FAIL flat_256: got %b want 0", obs_vp[300]); else pass_cnt++;
      end
    end
  endtask

  task automatic test_segment;
    int rows [4] = '{100, 110, 400, 420};
    ram[10] = 8'd20; ram[11] = 8'd200; ram[12] = 8'd50;
    for (int k = 0; k < 4; k++) begin
      scan_row(rows[k]);
      for (int c = 0; c < 512; c++) begin
        logic e;
        e = model_lit(c, rows[k], 0);
        total_cnt++;
        if (obs_vp[c] !== e || obs_rgb[c] !== (e ? WAVE_COLOR : 24'h0))
          $display("FAIL seg_row%0d_col%0d: got vp=%b rgb=%h want vp=%b", rows[k], c, obs_vp[c], obs_rgb[c], e);
        else pass_cnt++;
      end
      // Hand-derived spots: level = 255 - oy/2. The pair (20, 200) covers
      // columns 22-23, and the pair (200, 50) covers column 24.
      case (rows[k])
        100: begin total_cnt++; if (obs_vp[22] !== 1'b0) $display("FAIL seg_100_c22: got %b want 0", obs_vp[22]); else pass_cnt++; end
        110: begin total_cnt++; if ({obs_vp[22], obs_vp[23], obs_vp[24]} !== 3'b111) $display("FAIL seg_110: got %b%b%b want 111", obs_vp[22], obs_vp[23], obs_vp[24]); else pass_cnt++; end
        400: begin total_cnt++; if (obs_vp[24] !== 1'b1) $display("FAIL seg_400_c24: got %b want 1", obs_vp[24]); else pass_cnt++; end
        420: begin total_cnt++; if ({obs_vp[23], obs_vp[24]} !== 2'b10) $display("FAIL seg_420: got %b%b want 10", obs_vp[23], obs_vp[24]); else pass_cnt++; end
        default: ;
      endcase
    end
  endtask

  task automatic test_row_boundary;
    int rows [3] = '{510, 0, 300};
    ram[255] = 8'd0; ram[0] = 8'd255; ram[1] = 8'd255;
    for (int k = 0; k < 3; k++) begin
      scan_row(rows[k]);
      for (int c = 0; c < 512; c++) begin
        logic e;
        e = model_lit(c, rows[k], 0);
        total_cnt++;
        if (obs_vp[c] !== e)
          $display("FAIL bound_row%0d_col%0d: got vp=%b want vp=%b", rows[k], c, obs_vp[c], e);
        else pass_cnt++;
      end
    end
    // The last scan was row 300, so check row 0 again explicitly afterwards.
    total_cnt++; if (obs_vp[0] !== 1'b0) $display("FAIL bound_300_c0: got %b want 0", obs_vp[0]); else pass_cnt++;
    scan_row(0);
    total_cnt++; if (obs_vp[0] !== 1'b1 || obs_vp[1] !== 1'b1) $display("FAIL bound_0_c01: got %b%b want 11", obs_vp[0], obs_vp[1]); else pass_cnt++;
    scan_row(510);
    total_cnt++; if (obs_vp[511] !== 1'b1 || obs_vp[0] !== 1'b0) $display("FAIL bound_510: got c511=%b c0=%b want 1 0", obs_vp[511], obs_vp[0]); else pass_cnt++;
  endtask

  task automatic test_buffer_select;
    for (int i = 256; i < 512; i++) ram[i] = 8'd10;
    // Toggle read_index in the middle of window row 100. The half must hold.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        total_cnt++; if (read_address[8] !== 1'b0) $display("FAIL hold_half_k%0d: got %b want 0", k, read_address[8]); else pass_cnt++;
      end
      valid = 1'b1; y = 10'(Y_START + 100); x = 11'(X_START + k);
      if (k >= 2) read_index = 1'b1;
    end
    @(negedge clk);
    y = 10'(Y_START + 512); x = 11'(X_START);
    @(negedge clk);
    total_cnt++; if (wave_display_idle !== 1'b1) $display("FAIL idle_below: got %b want 1", wave_display_idle); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (read_address[8] !== 1'b1) $display("FAIL swap_half: got %b want 1", read_address[8]); else pass_cnt++;
    // Half 1 holds the value 10 everywhere, so row 490 (level 10) is fully lit.
    scan_row(490);
    for (int c = 0; c < 512; c++) begin
      logic e;
      e = model_lit(c, 490, 1);
      total_cnt++;
      if (obs_vp[c] !== e) $display("FAIL half1_row490_col%0d: got %b want %b", c, obs_vp[c], e); else pass_cnt++;
    end
    total_cnt++; if (obs_vp[0] !== 1'b1 || obs_vp[511] !== 1'b1) $display("FAIL half1_edges: got %b%b want 11", obs_vp[0], obs_vp[511]); else pass_cnt++;
    // Flip back inside the window. The half must stay 1 for the frame.
    read_index = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      valid = 1'b1; y = 10'(Y_START + 491); x = 11'(X_START + k);
      total_cnt++; if (read_address[8] !== 1'b1) $display("FAIL frame_half_k%0d: got %b want 1", k, read_address[8]); else pass_cnt++;
    end
  endtask

  task automatic test_invalid_and_reset;
    read_index = 1'b1;
    @(negedge clk);
    valid = 1'b0; x = 11'd300; y = 10'd100;
    @(negedge clk);
    total_cnt++; if (wave_display_idle !== 1'b1) $display("FAIL invalid_idle: got %b want 1", wave_display_idle); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (valid_pixel !== 1'b0) $display("FAIL invalid_vp: got %b want 0", valid_pixel); else pass_cnt++;
    // Light a pixel on row 490 of half 1, then pull reset between edges.
    for (int k = 0; k < 4; k++) begin
      valid = 1'b1; y = 10'(Y_START + 490); x = 11'(X_START + k);
      @(negedge clk);
    end
    total_cnt++; if (valid_pixel !== 1'b1) $display("FAIL pre_reset_vp: got %b want 1", valid_pixel); else pass_cnt++;
    #2 reset = 1'b0;
    #1;
    total_cnt++; if (valid_pixel !== 1'b0) $display("FAIL async_vp: got %b want 0", valid_pixel); else pass_cnt++;
    total_cnt++; if ({r, g, b} !== 24'h0) $display("FAIL async_rgb: got %h want 0", {r, g, b}); else pass_cnt++;
    total_cnt++; if (wave_display_idle !== 1'b0) $display("FAIL async_idle: got %b want 0", wave_display_idle); else pass_cnt++;
    total_cnt++; if (read_address[8] !== 1'b0) $display("FAIL async_half: got %b want 0", read_address[8]); else pass_cnt++;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    total_cnt++; if (valid_pixel !== 1'b0) $display("FAIL release_vp: got %b want 0", valid_pixel); else pass_cnt++;
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ram[i] = 8'h00;
    test_reset();
    test_flat();
    test_segment();
    test_row_boundary();
    test_buffer_select();
    test_invalid_and_reset();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_wave_display_reader
